vectored_interrupt_controller: RTL and testbench

Parametrised multi-channel interrupt controller for the single-cycle RV32 core. It replaces the fixed single-line controller and adds per-channel trigger mode, an enable mask, fixed priority, pending tracking and a trap-entry/`mret` handshake. It supplies the core with a trap request, the `mcause` value to write, and a vector-selection index.

---
 rtl/vectored_interrupt_controller.sv | 109 ++++++++++
 tb/tb_vectored_interrupt_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vectored_interrupt_controller.sv
// Multi-channel interrupt controller: synchronised edge/level inputs, enable mask,
// fixed lowest-index-wins priority, and a trapAck/complete handshake with the core.
module vectored_interrupt_controller #(
    parameter int                  CHANNELS     = 8,
    parameter logic [CHANNELS-1:0] EDGE_MASK    = '0,
    parameter int                  SYNC_STAGES  = 2,
    parameter logic [CHANNELS-1:0] ENABLE_RESET = '1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] irqBus,
    input  logic                globalEn,
    input  logic                enableWe,
    input  logic [CHANNELS-1:0] enableDi,
    input  logic                trapAck,
    input  logic                complete,
    output logic [CHANNELS-1:0] enable,
    output logic [CHANNELS-1:0] pending,
    output logic                interrupt,
    output logic                inService,
    output logic [4:0]          cause,
    output logic [31:0]         mcauseDi
);

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] r_prev;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_enable;
    logic                r_in_service;
    logic [4:0]          r_cause;

    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_eligible;
    logic [CHANNELS-1:0] w_clear;
    logic [CHANNELS-1:0] w_pending_nxt;
    logic [4:0]          w_winner;
    logic                w_found;
    logic                w_accept;
    logic                w_retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= irqBus;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_s & ~r_prev;
    assign w_eligible = r_pending & r_enable;

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_eligible[i] && !w_found) begin
                w_winner = 5'(i);
                w_found  = 1'b1;
            end
        end
    end

    // Handshake: interrupt is the request; trapAck in a cycle where interrupt=1 is the
    // acceptance. complete retires an active trap and takes precedence over trapAck.
    assign interrupt = globalEn & ~r_in_service & (|w_eligible);
    assign w_accept  = trapAck & interrupt;
    assign w_retire  = complete & r_in_service;

    // Edge channels: clear the accepted winner, a same-cycle rise still sets it.
    // Level channels simply follow the synchronised line.
    always_comb begin
        w_clear = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_clear[i] = w_accept && (w_winner == 5'(i));
        end
        w_pending_nxt = (EDGE_MASK & ((r_pending & ~w_clear) | w_rise))
                      | (~EDGE_MASK & w_s);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev       <= '0;
            r_pending    <= '0;
            r_enable     <= ENABLE_RESET;
            r_in_service <= 1'b0;
            r_cause      <= '0;
        end else begin
            r_prev    <= w_s;
            r_pending <= w_pending_nxt;
            if (enableWe) r_enable <= enableDi;
            if (w_retire) begin
                r_in_service <= 1'b0;
            end else if (w_accept) begin
                r_in_service <= 1'b1;
                r_cause      <= w_winner;
            end
        end
    end

    assign enable    = r_enable;
    assign pending   = r_pending;
    assign inService = r_in_service;
    assign cause     = r_in_service ? r_cause : w_winner;
    assign mcauseDi  = {1'b1, 26'b0, 5'd16 + cause};

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Bench for vectored_interrupt_controller: directed handshake scenarios followed by
// randomised traffic, all compared against a sample-history reference model.
module tb_vectored_interrupt_controller;

  localparam int CH = 8;
  localparam int SYNC = 2;
  localparam logic [CH-1:0] EDGE = 8'hFD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] irq, en_di, enable, pending;
  logic          g_en, en_we, t_ack, cmpl;
  logic          interrupt, in_service;
  logic [4:0]    cause;
  logic [31:0]   mcause;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vectored_interrupt_controller #(
    .CHANNELS(CH), .EDGE_MASK(EDGE), .SYNC_STAGES(SYNC), .ENABLE_RESET(8'hFF)
  ) dut (
    .clk(clk), .reset(rst_n), .irqBus(irq), .globalEn(g_en), .enableWe(en_we),
    .enableDi(en_di), .trapAck(t_ack), .complete(cmpl), .enable(enable),
    .pending(pending), .interrupt(interrupt), .inService(in_service),
    .cause(cause), .mcauseDi(mcause)
  );

  // reference model: raw samples kept as a history list, oldest = synchroniser output
  logic [CH-1:0] m_hist[$];
  logic [CH-1:0] m_prev, m_pend, m_en;
  logic          m_insvc;
  logic [4:0]    m_cause;

  function automatic logic [4:0] lowest(input logic [CH-1:0] v);
    int r = 0;
    if (v == 0) return 5'd0;
    while (!v[r]) r++;
    return 5'(r);
  endfunction

  function automatic logic exp_int();
    return g_en && !m_insvc && ((m_pend & m_en) != 0);
  endfunction

  function automatic logic [4:0] exp_cause();
    return m_insvc ? m_cause : lowest(m_pend & m_en);
  endfunction

  task automatic model_reset();
    m_hist = {};
    repeat (SYNC) m_hist.push_back('0);
    m_prev = '0; m_pend = '0; m_en = 8'hFF; m_insvc = 1'b0; m_cause = '0;
  endtask

  task automatic model_update();
    logic [CH-1:0] s, rise, nxt, clr;
    logic [4:0]    win;
    logic          acc;
    s    = m_hist[SYNC-1];
    rise = s & ~m_prev;
    win  = lowest(m_pend & m_en);
    acc  = t_ack && exp_int();
    clr  = acc ? (8'h01 << win) : 8'h00;
    nxt  = (((m_pend & ~clr) | rise) & EDGE) | (s & ~EDGE);
    if (cmpl && m_insvc) m_insvc = 1'b0;
    else if (acc) begin m_insvc = 1'b1; m_cause = win; end
    if (en_we) m_en = en_di;
    m_prev = s;
    m_pend = nxt;
    m_hist.push_front(irq);
    void'(m_hist.pop_back());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] c;
    c = exp_cause();
    chk({tag, ".pending"}, 32'(pending), 32'(m_pend));
    chk({tag, ".enable"}, 32'(enable), 32'(m_en));
    chk({tag, ".interrupt"}, 32'(interrupt), 32'(exp_int()));
    chk({tag, ".inService"}, 32'(in_service), 32'(m_insvc));
    chk({tag, ".cause"}, 32'(cause), 32'(c));
    chk({tag, ".mcause"}, mcause, 32'h8000_0000 + ((32'd16 + 32'(c)) % 32));
  endtask

  task automatic tick(input string tag);
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, ".pending"}, 32'(pending), 32'h0);
    chk({tag, ".enable"}, 32'(enable), 32'hFF);
    chk({tag, ".interrupt"}, 32'(interrupt), 32'h0);
    chk({tag, ".inService"}, 32'(in_service), 32'h0);
    chk({tag, ".cause"}, 32'(cause), 32'h0);
    chk({tag, ".mcause"}, mcause, 32'h8000_0010);
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; g_en = 1'b1; en_we = 1'b0; en_di = '0; t_ack = 1'b0; cmpl = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_values("reset");
    rst_n = 1'b1;
    tick("idle"); tick("idle");

    // single edge pulse on channel 3
    irq = 8'h08; tick("p3a"); irq = 8'h00; tick("p3b"); tick("p3c");
    chk("p3.pending", 32'(pending), 32'h08);
    chk("p3.interrupt", 32'(interrupt), 32'h1);
    chk("p3.cause", 32'(cause), 32'h3);
    chk("p3.mcause", mcause, 32'h8000_0013);
    t_ack = 1'b1; tick("p3ack"); t_ack = 1'b0;
    chk("p3ack.inService", 32'(in_service), 32'h1);
    cmpl = 1'b1; tick("p3cmpl"); cmpl = 1'b0;

    // priority between channels 2 and 5
    irq = 8'h24; tick("pri_a"); irq = 8'h00; tick("pri_b"); tick("pri_c");
    chk("pri.cause", 32'(cause), 32'h2);
    t_ack = 1'b1; tick("pri_ack"); t_ack = 1'b0;
    chk("pri_ack.pending", 32'(pending), 32'h20);
    chk("pri_ack.interrupt", 32'(interrupt), 32'h0);
    cmpl = 1'b1; tick("pri_cmpl"); cmpl = 1'b0;
    chk("pri_cmpl.interrupt", 32'(interrupt), 32'h1);
    chk("pri_cmpl.cause", 32'(cause), 32'h5);
    t_ack = 1'b1; tick("pri_ack5"); t_ack = 1'b0;
    cmpl = 1'b1; tick("pri_cmpl5"); cmpl = 1'b0;

    // enable mask and global enable
    irq = 8'h20; tick("msk_a"); irq = 8'h00; tick("msk_b"); tick("msk_c");
    en_we = 1'b1; en_di = 8'hDF; tick("msk_wr"); en_we = 1'b0;
    chk("msk.interrupt", 32'(interrupt), 32'h0);
    chk("msk.pending", 32'(pending), 32'h20);
    irq = 8'h01; tick("glb_a"); irq = 8'h00; tick("glb_b"); tick("glb_c");
    g_en = 1'b0; #1; check_all("glb_off");
    chk("glb_off.interrupt", 32'(interrupt), 32'h0);
    en_we = 1'b1; en_di = 8'hFF; tick("glb_wr"); en_we = 1'b0;
    g_en = 1'b1; #1; check_all("glb_on");
    chk("glb_on.interrupt", 32'(interrupt), 32'h1);
    t_ack = 1'b1; tick("glb_ack0"); t_ack = 1'b0;
    cmpl = 1'b1; tick("glb_cmpl0"); cmpl = 1'b0;
    t_ack = 1'b1; tick("glb_ack5"); t_ack = 1'b0;
    cmpl = 1'b1; tick("glb_cmpl5"); cmpl = 1'b0;

    // level channel 1
    irq = 8'h02; tick("lvl_a"); tick("lvl_b"); tick("lvl_c");
    t_ack = 1'b1; tick("lvl_ack"); t_ack = 1'b0;
    chk("lvl_ack.pending", 32'(pending), 32'h02);
    cmpl = 1'b1; tick("lvl_cmpl"); cmpl = 1'b0;
    irq = 8'h00; tick("lvl_d"); tick("lvl_e"); tick("lvl_f");
    chk("lvl_drop.pending", 32'(pending), 32'h00);

    // new edge on the trapAck cycle, then trapAck+complete, then ignored trapAck
    irq = 8'h01; tick("sim_a"); irq = 8'h00; tick("sim_b"); tick("sim_c");
    irq = 8'h01; tick("sim_d"); irq = 8'h00; tick("sim_e");
    t_ack = 1'b1; tick("sim_ack"); t_ack = 1'b0;
    chk("sim_ack.pending", 32'(pending), 32'h01);
    t_ack = 1'b1; cmpl = 1'b1; tick("sim_both"); t_ack = 1'b0; cmpl = 1'b0;
    chk("sim_both.inService", 32'(in_service), 32'h0);
    g_en = 1'b0; t_ack = 1'b1; tick("sim_ign"); t_ack = 1'b0; g_en = 1'b1;
    chk("sim_ign.pending", 32'(pending), 32'h01);
    t_ack = 1'b1; tick("sim_ack2"); t_ack = 1'b0;
    cmpl = 1'b1; tick("sim_cmpl2"); cmpl = 1'b0;

    // asynchronous reset in the middle of a trap
    irq = 8'h08; tick("ar_a"); irq = 8'h00; tick("ar_b"); tick("ar_c");
    t_ack = 1'b1; tick("ar_ack"); t_ack = 1'b0;
    irq = 8'h04; tick("ar_d"); irq = 8'h00; tick("ar_e"); tick("ar_f");
    @(posedge clk); #2 rst_n = 1'b0;
    model_reset();
    #1 reset_values("async_reset");
    @(negedge clk); rst_n = 1'b1;

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ (8'($urandom) & 8'($urandom));
      g_en  = ($urandom_range(0, 7) != 0);
      t_ack = ($urandom_range(0, 2) == 0);
      cmpl  = ($urandom_range(0, 4) == 0);
      en_we = ($urandom_range(0, 15) == 0);
      en_di = 8'($urandom) | 8'($urandom);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
